// File: rtl/pio_edge_irq.sv
// pio_edge_irq: Avalon-MM input PIO with synchroniser, per-bit edge capture, IRQ mask and saturating edge counter
module pio_edge_irq #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0] s_last, prev_q, edge_raw, edge_v, mask_q, mask_d, ec_q, ec_d;
  logic [SYNC_STAGES:0] arm_q;
  logic [15:0] count_q, count_d;
  logic [31:0] rd_q, rd_d;
  logic wr, any_edge, unused_wd;
  assign unused_wd = ^writedata;
  assign s_last = sync_q[SYNC_STAGES-1];
  assign wr = chipselect & ~write_n;
  assign edge_raw = EDGE_TYPE == 0 ? s_last & ~prev_q : EDGE_TYPE == 1 ? ~s_last & prev_q : s_last ^ prev_q;
  // arm_q fills with ones after reset; edges are ignored until the pipeline and prev have settled
  assign edge_v = arm_q[SYNC_STAGES] ? edge_raw : '0;
  assign any_edge = |edge_v;
  assign irq = |(ec_q & mask_q);
  assign readdata = rd_q;
  always_comb begin
    mask_d = wr && address == 2'd2 ? writedata[DATA_WIDTH-1:0] : mask_q;
    ec_d = (ec_q & ~(wr && address == 2'd3 ? writedata[DATA_WIDTH-1:0] : '0)) | edge_v;
    count_d = wr && address == 2'd1 ? {15'd0, any_edge} :
              any_edge && count_q != 16'hffff ? count_q + 16'd1 : count_q;
    rd_d = address == 2'd0 ? 32'(s_last) :
           address == 2'd1 ? {16'd0, count_q} :
           address == 2'd2 ? 32'(mask_q) : 32'(ec_q);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      prev_q  <= '0;
      arm_q   <= '0;
      mask_q  <= '0;
      ec_q    <= '0;
      count_q <= '0;
      rd_q    <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev_q  <= s_last;
      arm_q   <= {arm_q[SYNC_STAGES-1:0], 1'b1};
      mask_q  <= mask_d;
      ec_q    <= ec_d;
      count_q <= count_d;
      rd_q    <= rd_d;
    end
  end
endmodule
